i2c_master: RTL and testbench

Single-byte I2C controller: the initiating end of the bus our responder sits on. On a `start` pulse it issues START, the 7-bit address plus R/W bit, checks ACK, then writes or reads one data byte and issues STOP. SDA and SCL are open-drain, so each is driven by an output-enable that pulls the line low, and SCL timing is derived from the system clock. It sits between local control logic and the bus pads, and is the stimulus source for bench-testing our responder.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_master_if.sv | 27 ++
 rtl/i2c_quarter_tick.sv | 37 +++
 rtl/i2c_master.sv | 156 +++++++++++++++
 tb/tb_i2c_master.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// i2c_master shared definitions
// states, direction codes, quarter phases
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ADDR_ACK = 3'd3,
    ST_DATA     = 3'd4,
    ST_DATA_ACK = 3'd5,
    ST_STOP     = 3'd6
  } i2c_state_e;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_master_if.sv
// i2c_master control and pad bundle
// master = controller side, slave = user/pad side
interface i2c_master_if;

  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       nack;

  modport master (
    input  start, addr, rw, wdata, sda_in,
    output scl_oe, sda_oe, busy, done, rdata, nack
  );

  modport slave (
    output start, addr, rw, wdata, sda_in,
    input  scl_oe, sda_oe, busy, done, rdata, nack
  );

endinterface

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider
// tick on last clock of each quarter, 2-bit phase
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       i_en,
  output logic       o_tick,
  output logic [1:0] o_q
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_q;

  assign o_tick = i_en && (r_cnt == LAST);
  assign o_q    = r_q;

  // count clocks within a quarter; held at zero while disabled
  always_ff @(posedge clk) begin
    if (clr || !i_en) begin
      r_cnt <= '0;
      r_q   <= Q0;
    end else if (o_tick) begin
      r_cnt <= '0;
      r_q   <= r_q + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master.sv
// single-byte I2C controller
// START, addr+rw, ACK, one data byte, STOP
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         clr,
  i2c_master_if.master bus
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_ADDR = ST_ADDR;
  localparam logic [2:0] S_AACK = ST_ADDR_ACK;
  localparam logic [2:0] S_DATA = ST_DATA;
  localparam logic [2:0] S_DACK = ST_DATA_ACK;
  localparam logic [2:0] S_STOP = ST_STOP;

  logic [2:0] r_state;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic [7:0] r_wdata;
  logic       r_rw;
  logic       r_samp;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_rdata;
  logic       r_nack;

  logic       w_tick;
  logic [1:0] w_q;
  logic       w_end;
  logic       w_samp;
  logic       w_scl_lo;
  logic       w_sda_lo;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .clr    (clr),
    .i_en   (r_state != S_IDLE),
    .o_tick (w_tick),
    .o_q    (w_q)
  );

  assign w_end  = w_tick && (w_q == Q3);
  assign w_samp = w_tick && (w_q == Q2);

  // line drive: SCL low in Q0-Q1 of bit slots, SDA per state
  always_comb begin
    w_scl_lo = 1'b0;
    w_sda_lo = 1'b0;
    case (r_state)
      S_START: w_sda_lo = w_q[1];
      S_ADDR: begin
        w_scl_lo = ~w_q[1];
        w_sda_lo = ~r_shift[7];
      end
      S_AACK, S_DACK: w_scl_lo = ~w_q[1];
      S_DATA: begin
        w_scl_lo = ~w_q[1];
        w_sda_lo = (r_rw == I2C_WRITE) && ~r_shift[7];
      end
      S_STOP: begin
        w_scl_lo = ~w_q[1];
        w_sda_lo = (w_q != Q3);
      end
      default: ;
    endcase
  end

  assign bus.scl_oe = w_scl_lo;
  assign bus.sda_oe = w_sda_lo;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.rdata  = r_rdata;
  assign bus.nack   = r_nack;

  // transaction sequencer, bit counter and shift register
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_shift <= '0;
      r_wdata <= '0;
      r_rw    <= 1'b0;
      r_samp  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rdata <= '0;
      r_nack  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_samp) r_samp <= bus.sda_in;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
            r_nack  <= 1'b0;
            r_shift <= {bus.addr, bus.rw};
            r_rw    <= bus.rw;
            r_wdata <= bus.wdata;
            r_bit   <= '0;
          end
        end
        S_START: if (w_end) r_state <= S_ADDR;
        S_ADDR: begin
          if (w_end) begin
            r_shift <= {r_shift[6:0], 1'b0};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_AACK;
          end
        end
        S_AACK: begin
          if (w_end) begin
            if (r_samp) begin
              r_nack  <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift <= r_wdata;
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (r_rw == I2C_READ && w_samp)
            r_shift <= {r_shift[6:0], bus.sda_in};
          if (w_end) begin
            if (r_rw == I2C_WRITE)
              r_shift <= {r_shift[6:0], 1'b0};
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_DACK;
          end
        end
        S_DACK: begin
          if (w_end) begin
            if (r_rw == I2C_WRITE) r_nack <= r_samp;
            else r_rdata <= r_shift;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// i2c_master bench: bus responder model
// plus transaction-level expectations
module tb_i2c_master;

  localparam int CLK_DIV = 4;
  localparam int BOUND = 100 * CLK_DIV + 50;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  i2c_master_if bus();

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  logic resp_pull = 1'b0;
  assign bus.sda_in = ~(bus.sda_oe | resp_pull);

  logic       resp_en = 1'b0;
  logic [6:0] resp_addr = '0;
  logic       resp_dack = 1'b1;
  logic [7:0] resp_rd = '0;

  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  int         nrise = 0;
  int         n_scl_rise = 0;
  logic [7:0] rx = '0;
  logic       rw_r = 1'b0;
  logic       acked = 1'b0;
  logic [7:0] q_bytes[$];
  logic       q_rel[$];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rdata = '0;

  // bus responder: samples on SCL rise, drives on SCL fall
  always @(posedge clk) begin
    logic scl;
    logic sda;
    scl = ~bus.scl_oe;
    sda = bus.sda_in;
    if (clr) begin
      resp_pull <= 1'b0;
      nrise <= 0;
    end else begin
      if (!p_scl && scl) begin
        n_scl_rise <= n_scl_rise + 1;
        rx <= {rx[6:0], sda};
        nrise <= nrise + 1;
        if (nrise == 17) q_rel.push_back(sda);
      end
      if (p_scl && scl && p_sda && !sda) nrise <= 0;
      if (p_scl && scl && !p_sda && sda) resp_pull <= 1'b0;
      if (p_scl && !scl) begin
        resp_pull <= 1'b0;
        if (nrise == 8) begin
          q_bytes.push_back(rx);
          rw_r <= rx[0];
          acked <= resp_en && (rx[7:1] == resp_addr);
          resp_pull <= resp_en && (rx[7:1] == resp_addr);
        end else if (nrise >= 9 && nrise <= 16 && acked && rw_r) begin
          resp_pull <= ~resp_rd[3'(16 - nrise)];
        end else if (nrise == 17 && acked && !rw_r) begin
          q_bytes.push_back(rx);
          resp_pull <= resp_dack;
        end
      end
    end
    p_scl <= scl;
    p_sda <= sda;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] get_byte(input int i);
    return (i < q_bytes.size()) ? {1'b0, q_bytes[i]} : 9'h1ff;
  endfunction

  task automatic run_txn(input logic [6:0] a, input logic r,
                         input logic [7:0] w, input logic present,
                         input logic dack, input logic [7:0] rd,
                         input int poke);
    int cyc;
    int nbad;
    int ndone;
    int nbusy;
    int bb;
    int br;
    int bq;
    int exp_n;
    logic exp_nack;
    resp_en = present;
    resp_addr = a;
    resp_dack = dack;
    resp_rd = rd;
    bb = q_bytes.size();
    bq = q_rel.size();
    @(negedge clk);
    br = n_scl_rise;
    bus.addr = a;
    bus.rw = r;
    bus.wdata = w;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    nbad = 0;
    chk("busy_on", bus.busy, 1);
    while (!bus.done && cyc < BOUND) begin
      if (cyc == poke) begin
        bus.start = 1'b1;
        bus.wdata = ~w;
        bus.addr = ~a;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (!bus.done && !bus.busy) nbad++;
    end
    bus.start = 1'b0;
    exp_n = present ? 80 : 44;
    exp_nack = !present || (r == 1'b0 && !dack);
    if (present && r) exp_rdata = rd;
    chk("done_cyc", cyc, exp_n * CLK_DIV + 1);
    chk("busy_gap", nbad, 0);
    chk("busy_off", bus.busy, 0);
    chk("nack", bus.nack, exp_nack);
    chk("rdata", bus.rdata, exp_rdata);
    chk("addr_byte", get_byte(bb), {2'b0, a, r});
    if (present && !r) chk("data_byte", get_byte(bb + 1), {1'b0, w});
    chk("nbytes", q_bytes.size() - bb, (present && !r) ? 2 : 1);
    chk("scl_rises", n_scl_rise - br, present ? 19 : 10);
    if (present && r) begin
      chk("rd_rel9", (q_rel.size() > bq) ? q_rel[$] : 1'b0, 1);
    end
    ndone = 0;
    nbusy = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.busy) nbusy++;
    end
    chk("extra_done", ndone, 0);
    chk("idle_busy", nbusy, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.addr = '0;
    bus.rw = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_scl", bus.scl_oe, 0);
    chk("rst_sda", bus.sda_oe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_nack", bus.nack, 0);
    clr = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(7'h19, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, -1);
    run_txn(7'h19, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, -1);
    run_txn(7'h19, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00, -1);
    run_txn(7'h19, 1'b0, 8'hC3, 1'b1, 1'b0, 8'h00, -1);
    run_txn(7'h2B, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00, 100);

    bus.addr = 7'h19;
    bus.rw = 1'b0;
    bus.wdata = 8'hA5;
    resp_en = 1'b1;
    resp_addr = 7'h19;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4 * CLK_DIV + 5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_scl", bus.scl_oe, 0);
    chk("clr_sda", bus.sda_oe, 0);
    chk("clr_busy", bus.busy, 0);
    chk("clr_done", bus.done, 0);
    chk("clr_rdata", bus.rdata, 0);
    exp_rdata = '0;
    clr = 1'b0;
    repeat (4) @(negedge clk);
    run_txn(7'h19, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, -1);

    for (int i = 0; i < 12; i++) begin
      logic [6:0] a;
      logic [7:0] w;
      logic [7:0] rd;
      logic r;
      logic pr;
      logic dk;
      int pk;
      a = 7'($urandom);
      w = 8'($urandom);
      rd = 8'($urandom);
      r = 1'($urandom);
      pr = ($urandom_range(0, 3) != 0);
      dk = ($urandom_range(0, 3) != 0);
      pk = ($urandom_range(0, 1) != 0) ? $urandom_range(2, 170) : -1;
      run_txn(a, r, w, pr, dk, rd, pk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
